// File: rtl/seq_mult_param.sv
// Iterative shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH, one multiplier bit per clock,
// with a start/busy/done handshake. Define MULT_SIGNED_EN to build the signed (MULT) path.
module seq_mult_param #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               is_signed,
    input  logic [WIDTH-1:0]   data_a,
    input  logic [WIDTH-1:0]   data_b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t               state_reg;
    logic [WIDTH-1:0]     mcand_reg;
    logic [WIDTH-1:0]     mult_reg;
    logic [2*WIDTH-1:0]   acc_reg;
    logic [CNT_W-1:0]     cnt_reg;
    logic                 busy_reg;
    logic                 done_reg;
    logic [2*WIDTH-1:0]   product_reg;

    logic [WIDTH:0]       sum_next;
    logic [2*WIDTH-1:0]   acc_next;
    logic [WIDTH-1:0]     mag_a;
    logic [WIDTH-1:0]     mag_b;
    logic [2*WIDTH-1:0]   result_next;
    logic                 unused_acc_lsb;

    // The upper half absorbs the partial product with its carry; the shift drops acc[0].
    assign sum_next       = {1'b0, acc_reg[2*WIDTH-1:WIDTH]}
                          + {1'b0, (mult_reg[0] ? mcand_reg : {WIDTH{1'b0}})};
    assign acc_next       = {sum_next, acc_reg[WIDTH-1:1]};
    assign unused_acc_lsb = acc_reg[0];

`ifdef MULT_SIGNED_EN
    logic neg_reg;
    logic neg_in;

    // Iterate on magnitudes; the most negative value maps to 2^(WIDTH-1), still exact.
    always_comb begin
        mag_a       = (is_signed && data_a[WIDTH-1]) ? (~data_a + 1'b1) : data_a;
        mag_b       = (is_signed && data_b[WIDTH-1]) ? (~data_b + 1'b1) : data_b;
        neg_in      = is_signed & (data_a[WIDTH-1] ^ data_b[WIDTH-1]);
        result_next = neg_reg ? (~acc_next + 1'b1) : acc_next;
    end
`else
    logic unused_is_signed;

    assign unused_is_signed = is_signed;

    always_comb begin
        mag_a       = data_a;
        mag_b       = data_b;
        result_next = acc_next;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            mcand_reg   <= '0;
            mult_reg    <= '0;
            acc_reg     <= '0;
            cnt_reg     <= '0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            product_reg <= '0;
`ifdef MULT_SIGNED_EN
            neg_reg     <= 1'b0;
`endif
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        mcand_reg <= mag_a;
                        mult_reg  <= mag_b;
                        acc_reg   <= '0;
                        cnt_reg   <= CNT_W'(WIDTH);
                        busy_reg  <= 1'b1;
                        state_reg <= RUN;
`ifdef MULT_SIGNED_EN
                        neg_reg   <= neg_in;
`endif
                    end
                end
                RUN: begin
                    acc_reg  <= acc_next;
                    mult_reg <= mult_reg >> 1;
                    cnt_reg  <= cnt_reg - CNT_W'(1);
                    // Final iteration: publish the product and pulse done on the same edge.
                    if (cnt_reg == CNT_W'(1)) begin
                        state_reg   <= IDLE;
                        busy_reg    <= 1'b0;
                        done_reg    <= 1'b1;
                        product_reg <= result_next;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign busy    = busy_reg;
    assign done    = done_reg;
    assign product = product_reg;

endmodule

// File: tb/tb_seq_mult_param.sv
// Self-checking bench for seq_mult_param (WIDTH=32): directed cases plus random operands
// against a plain-arithmetic reference product.
module tb_seq_mult_param;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          is_signed;
    logic [W-1:0]  data_a;
    logic [W-1:0]  data_b;
    logic          busy;
    logic          done;
    logic [2*W-1:0] product;

    int            n_asserts = 0;
    int            n_fail    = 0;
    logic [2*W-1:0] last_prod = '0;

    seq_mult_param #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .is_signed (is_signed),
        .data_a    (data_a),
        .data_b    (data_b),
        .busy      (busy),
        .done      (done),
        .product   (product)
    );

    always #5 clk = ~clk;

    function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic s);
        longint sa;
        longint sb;
        longint unsigned ua;
        longint unsigned ub;
        ua = {32'b0, a};
        ub = {32'b0, b};
        sa = longint'($signed(a));
        sb = longint'($signed(b));
`ifdef MULT_SIGNED_EN
        if (s) return 64'(sa * sb);
`else
        if (s && (sa == sb + 1)) return 64'(ua * ub);
`endif
        return 64'(ua * ub);
    endfunction

    task automatic check(input string tag, input logic [2*W-1:0] obs, input logic [2*W-1:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%h required 0x%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive a request; one edge later the DUT must be busy and still show the old product.
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          input bit hold);
        data_a    = a;
        data_b    = b;
        is_signed = s;
        start     = 1'b1;
        step();
        check("busy_at_E0", 64'(busy), 64'd1);
        check("done_at_E0", 64'(done), 64'd0);
        check("prod_at_E0", product, last_prod);
        if (hold) begin
            data_a = $urandom;
            data_b = $urandom;
        end else begin
            start = 1'b0;
        end
        $display("launch a=0x%h b=0x%h signed=%0d hold=%0d", a, b, s, hold);
    endtask

    // Wait (bounded) for done; checks latency, product hold during RUN and the result.
    task automatic finish_op(input string tag, input logic [2*W-1:0] exp);
        int k;
        k = 0;
        do begin
            step();
            k++;
            if (!done) begin
                check({tag, "_busy_run"}, 64'(busy), 64'd1);
                check({tag, "_prod_hold"}, product, last_prod);
            end
        end while (!done && k < W + 4);
        start = 1'b0;
        check({tag, "_latency"}, 64'(k), 64'(W));
        check({tag, "_product"}, product, exp);
        check({tag, "_busy_done"}, 64'(busy), 64'd0);
        last_prod = exp;
        $display("%s: done after %0d cycles product=0x%h expected=0x%h", tag, k, product, exp);
    endtask

    task automatic quiet_after(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            step();
            check({tag, "_done_low"}, 64'(done), 64'd0);
            check({tag, "_busy_low"}, 64'(busy), 64'd0);
            check({tag, "_prod_keep"}, product, last_prod);
        end
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rs;
        bit           saw_done;

        reset     = 1'b1;
        start     = 1'b1;
        is_signed = 1'b0;
        data_a    = 32'd1;
        data_b    = 32'd1;
        step();
        step();
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_product", product, 64'd0);
        start = 1'b0;
        reset = 1'b0;
        step();
        check("post_reset_busy", 64'(busy), 64'd0);

        // 3 x 5 unsigned
        launch(32'd3, 32'd5, 1'b0, 1'b0);
        finish_op("mul3x5", 64'h0000_0000_0000_000F);
        quiet_after("mul3x5", 2);

        // all-ones, start held high through RUN
        launch(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1);
        finish_op("allones", 64'hFFFF_FFFE_0000_0001);
        quiet_after("allones", 3);

`ifdef MULT_SIGNED_EN
        launch(32'hFFFF_FFFD, 32'd5, 1'b1, 1'b0);
        finish_op("neg3x5", 64'hFFFF_FFFF_FFFF_FFF1);
        launch(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0);
        finish_op("minxmin", 64'h4000_0000_0000_0000);
`else
        launch(32'hFFFF_FFFD, 32'd5, 1'b1, 1'b0);
        finish_op("neg3x5_u", 64'h0000_0004_FFFF_FFF1);
`endif
        quiet_after("signed_dir", 1);

        // Abort: reset at cycle 10 of an operation
        launch(32'd123, 32'd456, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_product", product, 64'd0);
        last_prod = '0;
        saw_done = 1'b0;
        for (int i = 0; i < W + 4; i++) begin
            step();
            if (done) saw_done = 1'b1;
        end
        check("abort_no_done", 64'(saw_done), 64'd0);
        $display("abort: reset mid-operation, done seen afterwards=%0d", saw_done);
        launch(32'd7, 32'd6, 1'b0, 1'b0);
        finish_op("mul7x6", 64'd42);
        quiet_after("mul7x6", 1);

        // Back-to-back: new start issued in the done cycle
        launch(32'd2, 32'd9, 1'b0, 1'b0);
        finish_op("mul2x9", 64'd18);
        check("b2b_done_seen", 64'(done), 64'd1);
        launch(32'd4, 32'd4, 1'b0, 1'b0);
        finish_op("mul4x4", 64'd16);
        quiet_after("mul4x4", 1);

        // Random operands against the reference model
        for (int t = 0; t < 8; t++) begin
            ra = $urandom;
            rb = $urandom;
            rs = 1'($urandom_range(0, 1));
            if (t == 0) ra = 32'h8000_0000;
            if (t == 1) rb = 32'hFFFF_FFFF;
            launch(ra, rb, rs, t[0]);
            finish_op($sformatf("rand%0d", t), model(ra, rb, rs));
            quiet_after($sformatf("rand%0d", t), 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
